// File: rtl/bus_responder_6502.sv
// ---------------------------------------------------------------------------
// bus_responder_6502
//
// Memory/peripheral responder for the data-bus side of a 6502 core. It
// completes the bus cycles the CPU starts. It holds a small RAM, returns the
// NMI/RES/IRQ vectors, and provides a control register that drives IRQ_L and
// NMI_L. It also counts opcode fetches (SYNC reads). Reads can be stretched by
// WAIT_STATES cycles, signalled by pulling RDY low.
//
// Ports
//   phi0_in      in   1   clock, all state updates on rising edge
//   RES          in   1   synchronous active-high reset
//   AB           in  16   CPU address bus
//   RW           in   1   1 = read, 0 = write
//   SYNC         in   1   opcode-fetch indicator
//   DB_in        in   8   write data from the CPU
//   DB_out       out  8   read data to the CPU
//   DB_oe        out  1   DB_out valid / drive enable
//   RDY          out  1   0 = CPU must hold the current read cycle
//   IRQ_L        out  1   level interrupt request, active low
//   NMI_L        out  1   NMI request pulse, active low
//   fetch_count  out 16   accepted SYNC reads, saturating
// ---------------------------------------------------------------------------
module bus_responder_6502 #(
    parameter int          ADDR_W        = 10,
    parameter int          WAIT_STATES   = 0,
    parameter logic [15:0] RES_VEC       = 16'h0200,
    parameter logic [15:0] NMI_VEC       = 16'h0300,
    parameter logic [15:0] IRQ_VEC       = 16'h0380,
    parameter logic [15:0] CTRL_ADDR     = 16'hFF00,
    parameter int          NMI_PULSE     = 4,
    parameter logic [7:0]  UNMAPPED_DATA = 8'hEA
) (
    input  logic        phi0_in,
    input  logic        RES,
    input  logic [15:0] AB,
    input  logic        RW,
    input  logic        SYNC,
    input  logic [7:0]  DB_in,
    output logic [7:0]  DB_out,
    output logic        DB_oe,
    output logic        RDY,
    output logic        IRQ_L,
    output logic        NMI_L,
    output logic [15:0] fetch_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam logic [3:0] WS_LOAD  = 4'(WAIT_STATES);
    localparam logic [3:0] NMI_LOAD = 4'(NMI_PULSE);
    localparam int         RAM_SIZE = 1 << ADDR_W;

    logic [1:0]  r_state;
    logic [3:0]  r_wcnt;
    logic [15:0] r_addr;
    logic [7:0]  r_dout;
    logic        r_oe;
    logic        r_rdy;
    logic        r_irq_l;
    logic [3:0]  r_nmi_cnt;
    logic [15:0] r_fcnt;

    logic [7:0]  r_mem [0:RAM_SIZE-1];

    logic        w_accept;
    logic        w_wr_req;
    logic [15:0] w_addr;
    logic        w_is_ctrl;
    logic        w_is_vec;
    logic        w_is_ram;
    logic        w_nmi_active;
    logic [7:0]  w_rd_data;

    // The bus is only looked at outside WAIT. While waiting, the address
    // latched when the read was accepted is the one being decoded.
    assign w_accept     = (r_state != S_WAIT);
    assign w_wr_req     = w_accept & ~RW;
    assign w_addr       = (r_state == S_WAIT) ? r_addr : AB;
    assign w_is_ctrl    = (w_addr == CTRL_ADDR);
    assign w_is_vec     = (w_addr >= 16'hFFFA);
    assign w_is_ram     = ((w_addr >> ADDR_W) == 16'd0);
    assign w_nmi_active = (r_nmi_cnt != 4'd0);

    // Decode priority: control register, vectors, RAM, then unmapped.
    always_comb begin
        w_rd_data = UNMAPPED_DATA;
        if (w_is_ctrl) begin
            w_rd_data = {6'b0, w_nmi_active, ~r_irq_l};
        end else if (w_is_vec) begin
            case (w_addr[2:0])
                3'b010:  w_rd_data = NMI_VEC[7:0];
                3'b011:  w_rd_data = NMI_VEC[15:8];
                3'b100:  w_rd_data = RES_VEC[7:0];
                3'b101:  w_rd_data = RES_VEC[15:8];
                3'b110:  w_rd_data = IRQ_VEC[7:0];
                3'b111:  w_rd_data = IRQ_VEC[15:8];
                default: w_rd_data = UNMAPPED_DATA;
            endcase
        end else if (w_is_ram) begin
            w_rd_data = r_mem[w_addr[ADDR_W-1:0]];
        end
    end

    // RAM is not reset. It is written only on an accepted write that decodes
    // to RAM, so vector space and the control register are write-protected.
    always_ff @(posedge phi0_in) begin
        if (!RES && w_wr_req && !w_is_ctrl && !w_is_vec && w_is_ram) begin
            r_mem[w_addr[ADDR_W-1:0]] <= DB_in;
        end
    end

    always_ff @(posedge phi0_in) begin
        if (RES) begin
            r_state   <= S_IDLE;
            r_wcnt    <= 4'd0;
            r_addr    <= 16'd0;
            r_dout    <= 8'h00;
            r_oe      <= 1'b0;
            r_rdy     <= 1'b1;
            r_irq_l   <= 1'b1;
            r_nmi_cnt <= 4'd0;
            r_fcnt    <= 16'd0;
        end else begin
            if (w_nmi_active) begin
                r_nmi_cnt <= r_nmi_cnt - 4'd1;
            end

            // Control register write. A new NMI request is ignored while a
            // pulse is still running, so the pulse is never stretched.
            if (w_wr_req && w_is_ctrl) begin
                r_irq_l <= ~DB_in[0];
                if (DB_in[1] && !w_nmi_active) begin
                    r_nmi_cnt <= NMI_LOAD;
                end
            end

            case (r_state)
                S_WAIT: begin
                    if (r_wcnt == 4'd1) begin
                        r_state <= S_DATA;
                        r_rdy   <= 1'b1;
                        r_oe    <= 1'b1;
                        r_dout  <= w_rd_data;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                // IDLE and DATA both accept a new request, so zero-wait
                // reads can run back to back at one per cycle.
                default: begin
                    if (RW) begin
                        r_addr <= AB;
                        if (SYNC && (r_fcnt != 16'hFFFF)) begin
                            r_fcnt <= r_fcnt + 16'd1;
                        end
                        if (WAIT_STATES == 0) begin
                            r_state <= S_DATA;
                            r_oe    <= 1'b1;
                            r_dout  <= w_rd_data;
                        end else begin
                            r_state <= S_WAIT;
                            r_wcnt  <= WS_LOAD;
                            r_rdy   <= 1'b0;
                            r_oe    <= 1'b0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_oe    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign DB_out      = r_dout;
    assign DB_oe       = r_oe;
    assign RDY         = r_rdy;
    assign IRQ_L       = r_irq_l;
    assign NMI_L       = ~w_nmi_active;
    assign fetch_count = r_fcnt;

endmodule

// File: tb/tb_bus_responder_6502.sv
module tb_bus_responder_6502;

    localparam int N = 3;   // 0: WAIT_STATES=0, 1: WAIT_STATES=2, 2: WAIT_STATES=3

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res;
    logic [15:0] ab   [N];
    logic        rw   [N];
    logic        sync [N];
    logic [7:0]  dbi  [N];
    logic [7:0]  dbo  [N];
    logic        oe   [N];
    logic        rdy  [N];
    logic        irql [N];
    logic        nmil [N];
    logic [15:0] fc   [N];

    int passed = 0;
    int total  = 0;

    // Reference model state
    logic [7:0] mem [N][1024];
    logic       m_irq [N];
    int         m_fc  [N];

    bus_responder_6502 #(.WAIT_STATES(0)) u0 (
        .phi0_in(clk), .RES(res), .AB(ab[0]), .RW(rw[0]), .SYNC(sync[0]), .DB_in(dbi[0]),
        .DB_out(dbo[0]), .DB_oe(oe[0]), .RDY(rdy[0]), .IRQ_L(irql[0]), .NMI_L(nmil[0]),
        .fetch_count(fc[0]));
    bus_responder_6502 #(.WAIT_STATES(2)) u2 (
        .phi0_in(clk), .RES(res), .AB(ab[1]), .RW(rw[1]), .SYNC(sync[1]), .DB_in(dbi[1]),
        .DB_out(dbo[1]), .DB_oe(oe[1]), .RDY(rdy[1]), .IRQ_L(irql[1]), .NMI_L(nmil[1]),
        .fetch_count(fc[1]));
    bus_responder_6502 #(.WAIT_STATES(3)) u3 (
        .phi0_in(clk), .RES(res), .AB(ab[2]), .RW(rw[2]), .SYNC(sync[2]), .DB_in(dbi[2]),
        .DB_out(dbo[2]), .DB_oe(oe[2]), .RDY(rdy[2]), .IRQ_L(irql[2]), .NMI_L(nmil[2]),
        .fetch_count(fc[2]));

    // Expected read value from the memory map (no NMI pulse assumed active).
    function automatic logic [7:0] exp_read(int k, logic [15:0] a);
        case (a)
            16'hFF00: return {6'b0, 1'b0, m_irq[k]};
            16'hFFFA: return 8'h00;
            16'hFFFB: return 8'h03;
            16'hFFFC: return 8'h00;
            16'hFFFD: return 8'h02;
            16'hFFFE: return 8'h80;
            16'hFFFF: return 8'h03;
            default:  return (a < 16'd1024) ? mem[k][a[9:0]] : 8'hEA;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int k);
        rw[k] = 1'b0; ab[k] = 16'h8000; sync[k] = 1'b0; dbi[k] = 8'h00;
    endtask

    task automatic rd(int k, logic [15:0] a, logic s);
        rw[k] = 1'b1; ab[k] = a; sync[k] = s; dbi[k] = 8'h00;
    endtask

    task automatic wr(int k, logic [15:0] a, logic [7:0] d);
        rw[k] = 1'b0; ab[k] = a; sync[k] = 1'b0; dbi[k] = d;
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) idle(k);
        res = 1'b1;
        step();
        step();
        for (int k = 0; k < N; k++) begin
            total++;
            if ({rdy[k], oe[k], dbo[k], irql[k], nmil[k], fc[k]} !== {1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 16'h0000})
                $display("FAIL reset[%0d]: rdy=%b oe=%b dout=%h irq_l=%b nmi_l=%b fc=%h expected 1 0 00 1 1 0000",
                         k, rdy[k], oe[k], dbo[k], irql[k], nmil[k], fc[k]);
            else passed++;
            m_fc[k] = 0; m_irq[k] = 1'b0;
        end
        res = 1'b0;
    endtask

    task automatic fill_ram();
        for (int a = 0; a < 1024; a++) begin
            for (int k = 0; k < N; k++) begin
                logic [7:0] d;
                d = 8'($urandom);
                wr(k, 16'(a), d);
                mem[k][a] = d;
            end
            step();
        end
        for (int k = 0; k < N; k++) idle(k);
        step();
    endtask

    task automatic test_reset_vector();
        logic [15:0] vec [6];
        vec = '{16'hFFFC, 16'hFFFD, 16'hFFFA, 16'hFFFB, 16'hFFFE, 16'hFFFF};
        for (int i = 0; i < 6; i++) begin
            logic [7:0] e;
            e = exp_read(0, vec[i]);
            rd(0, vec[i], 1'b0);
            step();
            total++;
            if (oe[0] !== 1'b1 || dbo[0] !== e || rdy[0] !== 1'b1)
                $display("FAIL vector %h: oe=%b rdy=%b dout=%h expected oe=1 rdy=1 dout=%h", vec[i], oe[0], rdy[0], dbo[0], e);
            else passed++;
        end
        idle(0);
        step();
        total++;
        if (oe[0] !== 1'b0) $display("FAIL oe_drop: oe=%b expected 0", oe[0]);
        else passed++;
    endtask

    task automatic test_write_read();
        wr(0, 16'h0010, 8'hA9);
        step();
        mem[0][16] = 8'hA9;
        rd(0, 16'h0010, 1'b0);
        step();
        total++;
        if (oe[0] !== 1'b1 || dbo[0] !== 8'hA9)
            $display("FAIL raw_0010: oe=%b dout=%h expected oe=1 dout=a9", oe[0], dbo[0]);
        else passed++;
        rd(0, 16'h8000, 1'b0);
        step();
        total++;
        if (oe[0] !== 1'b1 || dbo[0] !== 8'hEA)
            $display("FAIL unmapped_8000: oe=%b dout=%h expected oe=1 dout=ea", oe[0], dbo[0]);
        else passed++;
        idle(0);
        step();
    endtask

    task automatic test_wait_states();
        for (int it = 0; it < 6; it++) begin
            logic [15:0] a;
            a = 16'($urandom_range(0, 1023));
            rd(1, a, 1'b1);
            step();
            m_fc[1]++;
            for (int w = 1; w <= 2; w++) begin
                total++;
                if (rdy[1] !== 1'b0 || oe[1] !== 1'b0)
                    $display("FAIL wait_cycle%0d: rdy=%b oe=%b expected rdy=0 oe=0", w, rdy[1], oe[1]);
                else passed++;
                // Bus noise during the wait must be ignored.
                ab[1] = 16'($urandom); rw[1] = 1'($urandom); sync[1] = 1'b1; dbi[1] = 8'($urandom);
                step();
            end
            total++;
            if (rdy[1] !== 1'b1 || oe[1] !== 1'b1 || dbo[1] !== mem[1][a[9:0]] || fc[1] !== 16'(m_fc[1]))
                $display("FAIL wait_data %h: rdy=%b oe=%b dout=%h fc=%0d expected rdy=1 oe=1 dout=%h fc=%0d",
                         a, rdy[1], oe[1], dbo[1], fc[1], mem[1][a[9:0]], m_fc[1]);
            else passed++;
            if (it == 0) begin
                total++;
                if (fc[1] !== 16'd1) $display("FAIL wait_fetch_count: fc=%0d expected 1", fc[1]);
                else passed++;
            end
        end
        idle(1);
        step();
    endtask

    task automatic test_irq_nmi();
        wr(0, 16'hFF00, 8'h01);
        step();
        m_irq[0] = 1'b1;
        total++;
        if (irql[0] !== 1'b0) $display("FAIL irq_assert: irq_l=%b expected 0", irql[0]);
        else passed++;
        rd(0, 16'hFF00, 1'b0);
        step();
        total++;
        if (oe[0] !== 1'b1 || dbo[0] !== 8'h01) $display("FAIL ctrl_read: oe=%b dout=%h expected oe=1 dout=01", oe[0], dbo[0]);
        else passed++;
        idle(0);
        repeat (3) step();
        total++;
        if (irql[0] !== 1'b0) $display("FAIL irq_hold: irq_l=%b expected 0", irql[0]);
        else passed++;

        wr(0, 16'hFF00, 8'h02);
        step();
        m_irq[0] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            logic en;
            en = (i <= 4) ? 1'b0 : 1'b1;
            total++;
            if (nmil[0] !== en) $display("FAIL nmi_pulse cycle %0d: nmi_l=%b expected %b", i, nmil[0], en);
            else passed++;
            if (i == 1) begin
                total++;
                if (irql[0] !== 1'b1) $display("FAIL irq_release: irq_l=%b expected 1", irql[0]);
                else passed++;
            end
            if (i == 3) begin
                total++;
                if (oe[0] !== 1'b1 || dbo[0] !== 8'h02)
                    $display("FAIL ctrl_nmi_status: oe=%b dout=%h expected oe=1 dout=02", oe[0], dbo[0]);
                else passed++;
            end
            if (i == 1)      wr(0, 16'hFF00, 8'h02);
            else if (i == 2) rd(0, 16'hFF00, 1'b0);
            else             idle(0);
            step();
        end
    endtask

    task automatic test_random();
        logic [15:0] last_wr;
        last_wr = 16'h0010;
        for (int n = 0; n < 400; n++) begin
            logic [15:0] a;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 6)       a = 16'($urandom_range(0, 1023));
            else if (sel == 6) a = 16'hFFFA + 16'($urandom_range(0, 5));
            else if (sel == 7) a = 16'hFF00;
            else if (sel == 8) a = 16'($urandom_range(16'h0400, 16'hFEFF));
            else               a = last_wr;
            if ($urandom_range(0, 3) != 0) begin
                logic [7:0] e;
                logic s;
                s = 1'($urandom);
                e = exp_read(0, a);
                rd(0, a, s);
                step();
                if (s) m_fc[0]++;
                total++;
                if (oe[0] !== 1'b1 || rdy[0] !== 1'b1 || dbo[0] !== e || fc[0] !== 16'(m_fc[0]))
                    $display("FAIL rand_read %h: oe=%b rdy=%b dout=%h fc=%0d expected oe=1 rdy=1 dout=%h fc=%0d",
                             a, oe[0], rdy[0], dbo[0], fc[0], e, m_fc[0]);
                else passed++;
            end else begin
                logic [7:0] d;
                if (a == 16'hFF00) a = 16'h0123;
                d = 8'($urandom);
                wr(0, a, d);
                step();
                if (a < 16'd1024) mem[0][a[9:0]] = d;
                last_wr = a;
                total++;
                if (oe[0] !== 1'b0 || rdy[0] !== 1'b1)
                    $display("FAIL rand_write %h: oe=%b rdy=%b expected oe=0 rdy=1", a, oe[0], rdy[0]);
                else passed++;
            end
        end
        idle(0);
        step();
    endtask

    task automatic test_reset_mid();
        wr(2, 16'h0020, 8'h5A);
        step();
        mem[2][32] = 8'h5A;
        wr(2, 16'hFF00, 8'h02);
        step();
        rd(2, 16'h0020, 1'b1);
        step();
        total++;
        if (rdy[2] !== 1'b0 || nmil[2] !== 1'b0 || fc[2] !== 16'd1)
            $display("FAIL mid_pre: rdy=%b nmi_l=%b fc=%0d expected rdy=0 nmi_l=0 fc=1", rdy[2], nmil[2], fc[2]);
        else passed++;
        ab[2] = 16'hFFFC; rw[2] = 1'b1;
        step();
        res = 1'b1;
        for (int k = 0; k < N; k++) idle(k);
        step();
        res = 1'b0;
        for (int k = 0; k < N; k++) begin m_fc[k] = 0; m_irq[k] = 1'b0; end
        total++;
        if ({rdy[2], oe[2], nmil[2], irql[2], fc[2]} !== {1'b1, 1'b0, 1'b1, 1'b1, 16'd0})
            $display("FAIL mid_reset: rdy=%b oe=%b nmi_l=%b irq_l=%b fc=%0d expected 1 0 1 1 0",
                     rdy[2], oe[2], nmil[2], irql[2], fc[2]);
        else passed++;
        rd(2, 16'h0020, 1'b0);
        step();
        idle(2);
        for (int w = 1; w <= 3; w++) begin
            total++;
            if (rdy[2] !== 1'b0) $display("FAIL mid_wait%0d: rdy=%b expected 0", w, rdy[2]);
            else passed++;
            step();
        end
        total++;
        if (rdy[2] !== 1'b1 || oe[2] !== 1'b1 || dbo[2] !== 8'h5A)
            $display("FAIL mid_ram_kept: rdy=%b oe=%b dout=%h expected rdy=1 oe=1 dout=5a", rdy[2], oe[2], dbo[2]);
        else passed++;
        step();
    endtask

    task automatic test_saturation();
        rd(0, 16'h0000, 1'b1);
        repeat (65534) step();
        total++;
        if (fc[0] !== 16'hFFFE) $display("FAIL sat_pre: fc=%h expected fffe", fc[0]);
        else passed++;
        step();
        total++;
        if (fc[0] !== 16'hFFFF) $display("FAIL sat_reach: fc=%h expected ffff", fc[0]);
        else passed++;
        repeat (5) step();
        total++;
        if (fc[0] !== 16'hFFFF) $display("FAIL sat_hold: fc=%h expected ffff", fc[0]);
        else passed++;
        idle(0);
        step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        res = 1'b1;
        for (int k = 0; k < N; k++) idle(k);
        test_reset();
        fill_ram();
        test_reset_vector();
        test_write_read();
        test_wait_states();
        test_irq_nmi();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bus_responder_6502.md
Name: bus_responder_6502

Overview:
- Synthesizable memory/peripheral responder for the data-bus side of top_6502C. It completes the bus cycles that the CPU initiates.
- Decodes AB/RW each cycle and returns read data with a programmable number of wait states, signalled on RDY. Accepts writes into internal RAM.
- Serves the NMI/RES/IRQ vectors and provides a control register that drives IRQ_L and NMI_L.
- Counts opcode fetches using SYNC. Used as the CPU's system memory in simulation benches and on FPGA bring-up.

Parameters:
- ADDR_W, 10, log2 of RAM size; RAM is mapped at 0x0000 to 2^ADDR_W-1.
- WAIT_STATES, 0, RDY-low cycles inserted before each read's data (0..15).
- RES_VEC, 16'h0200, value returned at FFFC/FFFD.
- NMI_VEC, 16'h0300, value returned at FFFA/FFFB.
- IRQ_VEC, 16'h0380, value returned at FFFE/FFFF.
- CTRL_ADDR, 16'hFF00, address of the control/status register.
- NMI_PULSE, 4, number of cycles NMI_L is held low per NMI request (1..15).
- UNMAPPED_DATA, 8'hEA, read value for unmapped addresses (NOP).

Ports:
- phi0_in  input  1  system clock; all state updates on its rising edge.
- RES  input  1  synchronous, active-high reset.
- AB  input  16  CPU address bus.
- RW  input  1  1 = read, 0 = write.
- SYNC  input  1  CPU opcode-fetch indicator; qualifies reads.
- DB_in  input  8  write data from the CPU.
- DB_out  output  8  read data to the CPU.
- DB_oe  output  1  DB_out valid/drive enable.
- RDY  output  1  0 = CPU must hold the current read cycle.
- IRQ_L  output  1  level interrupt request, active low.
- NMI_L  output  1  NMI request pulse, active low.
- fetch_count  output  16  number of accepted SYNC reads, saturating.

Behaviour:
- Reset values (cycle after RES=1):
  - RDY=1, DB_oe=0, DB_out=8'h00, IRQ_L=1, NMI_L=1, fetch_count=0, FSM=IDLE.
  - RAM contents are not cleared.
  - RES takes priority over all other events.
- FSM has three states: IDLE, WAIT, DATA.
- IDLE samples AB/RW/DB_in/SYNC every cycle.
  - Read with WAIT_STATES=0: go to DATA.
  - Read with WAIT_STATES>0: go to WAIT, load wcnt=WAIT_STATES.
  - Write: perform it (below) and stay in IDLE.
- Read timing, request sampled at cycle t:
  - WAIT_STATES=0: DB_out/DB_oe=1 at t+1; RDY stays 1.
  - WAIT_STATES=W: RDY=0 during t+1..t+W; DB_oe=0 while waiting; at t+W+1, RDY=1, DB_oe=1, DB_out=data.
- In WAIT, AB/RW/SYNC are ignored; data comes from the address latched at t. wcnt decrements each cycle and WAIT→DATA when wcnt reaches 1.
- DATA lasts one cycle. It samples the next request in that same cycle with the same rules as IDLE, so back-to-back zero-wait reads run one per cycle. DB_oe drops to 0 only after a cycle in which no read was sampled.
- Writes:
  - Never stall; RDY stays 1.
  - RAM is updated at t+1. Writes to ROM vector space or unmapped addresses are ignored.
  - Write to CTRL_ADDR: bit0 → IRQ_L=~bit0 (level, held). bit1=1 → start an NMI pulse, NMI_L=0 for NMI_PULSE cycles starting t+1.
  - Writing bit1=1 while a pulse is active is ignored; the pulse is not retriggered.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Address decode priority, highest first:
  1. CTRL_ADDR — reads return {6'b0, nmi_active, ~IRQ_L}.
  2. FFFA-FFFF — vectors, low byte at the even address.
  3. RAM range.
  4. Everything else → UNMAPPED_DATA.
- fetch_count increments by 1 when a read with SYNC=1 is sampled, whether or not wait states follow. It saturates at 16'hFFFF with no wrap.
- RES asserted mid-WAIT or mid-NMI pulse aborts the operation: RDY=1 and NMI_L=1 the next cycle; the pending read is discarded.
- A write to CTRL_ADDR with bit1=1 in the same cycle as RES: RES wins and no pulse is generated.

Test Plan:
- Reset vector, WAIT_STATES=0: RES 2 cycles, then reads FFFC and FFFD → DB_out=8'h00 then 8'h02, each 1 cycle after its address, RDY never 0.
- Write then read, zero wait: write 8'hA9 to 0x0010, next cycle read 0x0010 → DB_out=8'hA9, DB_oe=1 the following cycle; read 0x8000 → 8'hEA.
- Wait states, WAIT_STATES=2: read 0x0010 with SYNC=1 → RDY=0 for exactly 2 cycles and data on the 3rd; a changed AB during the wait is ignored; fetch_count=1.
- Interrupt control:
  - Write 8'h01 to FF00 → IRQ_L=0 held; read FF00 → 8'h01.
  - Write 8'h02 → NMI_L=0 for exactly 4 cycles; a second 8'h02 during the pulse does not extend it.
- Reset mid-operation: WAIT_STATES=3, assert RES in the 2nd wait cycle → next cycle RDY=1, DB_oe=0, NMI_L=1, fetch_count=0; a RAM byte written before reset is still readable.
- Saturation: force 65536 SYNC reads → fetch_count holds at 16'hFFFF.
